fetch_decode_buffer: RTL and testbench
======================================

// Module: fetch_decode_buffer
// PURPOSE
//  IF/ID boundary buffer between the fetch stage and the decode stage.
//  Captures {instruction, pc_8} from fetch into a small FIFO.
//  Presents the oldest entry to decode with a valid/ready handshake.
//  Drops all queued entries on a taken-branch flush.
//  Drives in_ready back toward fetch as the future PC-enable (stall) source.
// PARAMETERS
//  WIDTH      18      width of instruction and pc_8 fields
//  DEPTH      2       number of FIFO entries, >=1; need not be a power of 2
//  NOP_INSTR  18'h0   instruction_out value whenever out_valid=0
// PORTS
//  clk              in   1              rising-edge clock
//  reset            in   1              asynchronous reset, active-low
//  in_valid         in   1              fetch presents a valid instruction
//  instruction_in   in   WIDTH          instruction from fetch
//  pc_8_in          in   WIDTH          pc_8 from fetch
//  in_ready         out  1              buffer can accept a push this cycle
//  flush            in   1              taken branch (pc_src); discard all entries
//  out_valid        out  1              head entry is valid
//  instruction_out  out  WIDTH          head instruction, NOP_INSTR when empty
//  pc_8_out         out  WIDTH          head pc_8, 0 when empty
//  out_ready        in   1              decode accepts head this cycle
//  count            out  $clog2(DEPTH+1)  number of entries held
//  overrun          out  1              sticky: push attempted while full
// BEHAVIOUR
//  - Reset (reset=0, async): count=0, rd_ptr=wr_ptr=0, overrun=0.
//    Outputs during and after reset: out_valid=0, instruction_out=NOP_INSTR, pc_8_out=0, in_ready=1.
//  - Storage is a DEPTH-entry register array of {instruction, pc_8}.
//    Head is read combinationally at rd_ptr.
//  - in_ready  = (count < DEPTH). Depends on state only; no combinational path from out_ready.
//  - out_valid = (count != 0).
//    instruction_out and pc_8_out show the head entry when valid, else NOP_INSTR and 0.
//  - push = in_valid & in_ready & ~flush
//  - pop  = out_valid & out_ready & ~flush
//  - On clk, when not flushing:
//    - push: write mem[wr_ptr] and advance wr_ptr.
//    - pop: advance rd_ptr.
//    - count += push - pop. Simultaneous push and pop leaves count unchanged.
//  - Pointers wrap from DEPTH-1 to 0.
//  - Latency: a pushed entry is visible at the output the cycle after the push (1 cycle).
//  - Full: push is refused even if a pop occurs in the same cycle (in_ready=0).
//    An entry is admitted in the next cycle at the earliest.
//  - Empty: out_ready is ignored; no pop and no pointer movement.
//  - Flush (synchronous, highest priority):
//    - Next cycle: count=0, rd_ptr=wr_ptr=0, out_valid=0.
//    - A same-cycle input is dropped and the head is not consumed.
//    - Array contents are left unchanged (don't care).
//  - overrun: set on clk when in_valid & ~in_ready & ~flush.
//    Held until reset; not cleared by flush.
//  - Reset asserted mid-operation discards all entries immediately (async). overrun clears.
//  - No X on outputs after reset, for any input sequence.
// TESTING
//  1. Reset with reset=0 and random inputs -> out_valid=0, instruction_out=0, pc_8_out=0, in_ready=1, count=0, overrun=0.
//  2. Push 18'h12345 / pc_8 18'h8, out_ready=1 -> next cycle out_valid=1 with the same values.
//     Following cycle (no push) -> out_valid=0.
//  3. out_ready=0; push A, B, then C -> count=2, in_ready=0, C dropped, overrun=1.
//     Then out_ready=1 -> A then B delivered in order, count=0.
//  4. count=1 (DEPTH=2); push and pop in the same cycle -> count stays 1 and the new entry becomes head.
//     With DEPTH=3, run 10 back-to-back push/pop cycles -> data stays in order across pointer wrap.
//  5. count=2; flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, input not stored, overrun unchanged.
//  6. count=2; reset pulsed low between clock edges -> outputs go to reset values immediately.
//     After release, the first push is delivered normally.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// IF/ID boundary buffer: small FIFO of {instruction, pc_8} between fetch and decode.
// A taken-branch flush drops all queued entries; in_ready back-pressures the fetch PC.
module fetch_decode_buffer #(
    parameter int               WIDTH     = 18,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             instruction_in,
    input  logic [WIDTH-1:0]             pc_8_in,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             instruction_out,
    output logic [WIDTH-1:0]             pc_8_out,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overrun
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc8;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic            push, pop;
    entry_t          head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready is a pure function of state so fetch never sees a path from decode's out_ready
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign head            = mem[rd_ptr];
    assign instruction_out = out_valid ? head.instr : NOP_INSTR;
    assign pc_8_out        = out_valid ? head.pc8   : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage has no reset; outputs are masked by out_valid so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{instr: instruction_in, pc8: pc_8_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           overrun <= 1'b0;
        else if (in_valid & ~in_ready & ~flush) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: DEPTH=2 and DEPTH=3 instances share stimulus,
// each compared against its own queue-based reference model.
module tb_fetch_decode_buffer;
    localparam int W = 18;

    logic clk = 1'b0, reset = 1'b0;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [W-1:0] instr_in = '0, pc_in = '0;

    logic rdy2, vld2, ovr2, rdy3, vld3, ovr3;
    logic [W-1:0] ins2, pc2, ins3, pc3;
    logic [1:0] cnt2, cnt3;

    typedef logic [2*W-1:0] q_t[$];
    q_t   m2, m3;
    logic mo2 = 1'b0, mo3 = 1'b0;
    int   total = 0, bad = 0;

    always #5 clk = ~clk;

    fetch_decode_buffer #(.WIDTH(W), .DEPTH(2), .NOP_INSTR('0)) d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction_in(instr_in),
        .pc_8_in(pc_in), .in_ready(rdy2), .flush(flush), .out_valid(vld2),
        .instruction_out(ins2), .pc_8_out(pc2), .out_ready(out_ready),
        .count(cnt2), .overrun(ovr2));

    fetch_decode_buffer #(.WIDTH(W), .DEPTH(3), .NOP_INSTR('0)) d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction_in(instr_in),
        .pc_8_in(pc_in), .in_ready(rdy3), .flush(flush), .out_valid(vld3),
        .instruction_out(ins3), .pc_8_out(pc3), .out_ready(out_ready),
        .count(cnt3), .overrun(ovr3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input q_t q, input int cap, input logic ov,
                           input logic vld, input logic [W-1:0] ins, input logic [W-1:0] pc,
                           input logic rdy, input logic [1:0] cnt, input logic ovr);
        logic [W-1:0] e_ins, e_pc;
        e_ins = (q.size() != 0) ? q[0][2*W-1:W] : '0;
        e_pc  = (q.size() != 0) ? q[0][W-1:0]   : '0;
        chk({tag, ".out_valid"}, 32'(vld), 32'(q.size() != 0));
        chk({tag, ".instr"},     32'(ins), 32'(e_ins));
        chk({tag, ".pc_8"},      32'(pc),  32'(e_pc));
        chk({tag, ".in_ready"},  32'(rdy), 32'(q.size() < cap));
        chk({tag, ".count"},     32'(cnt), 32'(q.size()));
        chk({tag, ".overrun"},   32'(ovr), 32'(ov));
    endtask

    task automatic check_all(input string tag);
        chk_dut({tag, ".d2"}, m2, 2, mo2, vld2, ins2, pc2, rdy2, cnt2, ovr2);
        chk_dut({tag, ".d3"}, m3, 3, mo3, vld3, ins3, pc3, rdy3, cnt3, ovr3);
    endtask

    // Reference: a bounded queue; push admitted only if there was room before the edge.
    task automatic mstep(input q_t qi, input int cap, input logic ovi,
                         output q_t qo, output logic ovo);
        bit had_room, do_pop;
        had_room = qi.size() < cap;
        do_pop   = (qi.size() != 0) && out_ready;
        ovo = ovi | (in_valid && !had_room && !flush);
        qo  = qi;
        if (flush) qo = {};
        else begin
            if (do_pop) void'(qo.pop_front());
            if (in_valid && had_room) qo.push_back({instr_in, pc_in});
        end
    endtask

    task automatic step(input string tag);
        q_t n2, n3;
        logic o2, o3;
        mstep(m2, 2, mo2, n2, o2);
        mstep(m3, 3, mo3, n3, o3);
        @(posedge clk);
        #1;
        if (!reset) begin
            m2 = {}; m3 = {}; mo2 = 1'b0; mo3 = 1'b0;
        end else begin
            m2 = n2; m3 = n3; mo2 = o2; mo3 = o3;
        end
        check_all(tag);
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] ins, input logic [W-1:0] pc,
                         input logic ordy, input logic fl);
        in_valid = iv; instr_in = ins; pc_in = pc; out_ready = ordy; flush = fl;
    endtask

    initial begin
        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            step("reset");
        end
        drive(0, '0, '0, 0, 0);
        reset = 1'b1;
        step("post_reset");

        // single push then drain
        drive(1, 18'h12345, 18'h8, 1, 0);
        step("push1");
        drive(0, '0, '0, 1, 0);
        step("pop1");

        // fill and overflow with decode stalled, then drain in order
        drive(1, 18'h0A0A0, 18'h10, 0, 0); step("fillA");
        drive(1, 18'h0B0B0, 18'h14, 0, 0); step("fillB");
        drive(1, 18'h0C0C0, 18'h18, 0, 0); step("fillC");
        drive(1, 18'h0D0D0, 18'h1C, 0, 0); step("fillD");
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 4; i++) step("drain");

        // one entry then simultaneous push/pop, back-to-back for pointer wrap
        drive(1, 18'h11111, 18'h20, 0, 0); step("pp_seed");
        for (int i = 0; i < 10; i++) begin
            drive(1, W'(18'h20000 + i), W'(18'h24 + 4*i), 1, 0);
            step("pushpop");
        end
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 3; i++) step("pp_drain");

        // flush with a same-cycle input
        drive(1, 18'h0E0E0, 18'h40, 0, 0); step("fl_fill0");
        drive(1, 18'h0F0F0, 18'h44, 0, 0); step("fl_fill1");
        drive(1, 18'h12121, 18'h48, 1, 1); step("flush");
        drive(0, '0, '0, 1, 0);            step("post_flush");

        // asynchronous reset between edges
        drive(1, 18'h13131, 18'h50, 0, 0); step("ar_fill0");
        drive(1, 18'h14141, 18'h54, 0, 0); step("ar_fill1");
        drive(1, 18'h15151, 18'h58, 0, 0); step("ar_fill2");
        drive(0, '0, '0, 0, 0);
        #2 reset = 1'b0;
        #1;
        m2 = {}; m3 = {}; mo2 = 1'b0; mo3 = 1'b0;
        check_all("async_reset");
        #1 reset = 1'b1;
        drive(1, 18'h16161, 18'h5C, 1, 0); step("ar_push");
        drive(0, '0, '0, 1, 0);            step("ar_pop");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), W'($urandom), W'($urandom),
                  1'($urandom), ($urandom_range(15) == 0));
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
